rename_multi: RTL
=================

# rename_multi

Parametrised successor to the single-station rename stage of the Qu processor. Renames one uop per cycle against an internal ROB-tag table. Dispatches the uop into one of `RS_COUNT` reservation stations, allocating free slots from per-station bitmaps. Applies valid/ready backpressure on ROB-full or station-full, bypasses same-cycle CDB broadcasts into operands, and supports a flush. Sits between decode and the reservation stations / ROB.

## Interface
Parameters:
- `RS_COUNT`, 2: number of reservation stations.
- `RS_DEPTH`, 8: slots per station, power of two.
- `ROB_DEPTH`, 16: ROB entries; tag width `ROB_AW = $clog2(ROB_DEPTH)`.
- `PRF_DEPTH`, 32: physical registers; register index width `PRF_AW = $clog2(PRF_DEPTH)`.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `uop_in` in `uop_t`: uop; valid when `uop_in.uop_ic.optype[0]`=1.
- `uop_rs_sel_in` in `$clog2(RS_COUNT)`: target station index.
- `uop_ready_out` out 1: uop accepted this cycle if valid.
- `phy_rf_rs1_addr_out`, `phy_rf_rs2_addr_out` out `PRF_AW`: RF read addresses.
- `phy_rf_rs1_data_in`, `phy_rf_rs2_data_in` in 32: RF read data, combinational.
- `res_st_wr_en_out` out `RS_COUNT`: one-hot station write enable.
- `res_st_wr_addr_out` out `$clog2(RS_DEPTH)`: allocated slot.
- `res_st_data_out` out `res_st_cell_t`: cell; fields `qj_valid`/`qk_valid` mark a pending tag.
- `res_st_release_in` out-of-band in `RS_COUNT`: per-station slot-release pulse.
- `res_st_release_addr_in` in `RS_COUNT*$clog2(RS_DEPTH)`: released slot per station.
- `rob_tail_ptr` in `ROB_AW`: tag for the incoming uop.
- `rob_full_in` in 1: ROB cannot accept.
- `rob_incr_tail_ptr` out 1: pulse on accept.
- `cdb_valid_in` in 1, `cdb_rob_addr_in` in `ROB_AW`, `cdb_data_in` in 32: result broadcast.
- `flush_in` in 1: squash all in-flight state.

## Operation
- `accept = valid & uop_ready_out`.
- `uop_ready_out = rst & !flush_in & !rob_full_in & |free[uop_rs_sel_in]`.
- Out-of-range `uop_rs_sel_in` (≥`RS_COUNT`) → ready=0.
- Slot allocation: lowest-index set bit of `free[sel]`. On accept, that bit clears.
- `res_st_release_in[s]` sets `free[s][addr]`. Release of an already-free slot has no effect. A release is visible to allocation the next cycle, not combinationally.
- Tag table: per register, `tag[PRF_DEPTH]` (`ROB_AW`) plus `tv` valid bit.
- Operand rules, rs1 (rs2 identical → qk/vk):
  - rs1==0 → `qj_valid`=0, `vj`=0.
  - `tv[rs1]` and CDB hit (`cdb_valid_in` & `cdb_rob_addr_in==tag[rs1]`) → `qj_valid`=0, `vj=cdb_data_in`.
  - `tv[rs1]`, no hit → `qj_valid`=1, `qj=tag[rs1]`, `vj`=0.
  - else → `qj_valid`=0, `vj=phy_rf_rs1_data_in`.
- Sources always read the pre-update table, so rd==rs1 on the same uop yields the old mapping.
- Other cell fields:
  - `a` = imm if `imm_valid`, else 0.
  - `pc` = uop pc.
  - `rob_addr = rob_tail_ptr`.
  - `dest` = rd if `rd_valid`, else 0.
  - `op = uop_in[RES_ST_OP_WIDTH-1:0]`.
  - `busy`=1.
- `res_st_wr_en_out[sel]` = accept; all other bits 0.
- Tag update on accept with `rd_valid` & rd≠0: `tag[rd]<=rob_tail_ptr`, `tv[rd]<=1`.
- CDB clear: every register with `tv`=1 and a matching tag gets `tv<=0`. A same-cycle rename write to that register takes precedence and leaves `tv`=1 with the new tag.
- `flush_in`:
  - Next edge: all `tv`←0 and all `free` bits←1.
  - Same cycle: ready=0, no write, no tail increment.
  - Flush dominates release and CDB.

## Timing
- Rename and dispatch are zero-latency: the RS write and tail increment occur in the accept cycle. Table and bitmap updates are visible the next cycle.
- Upstream holds `uop_in` stable while valid & !ready.
- Reset (rst=0, asynchronous):
  - All `tv`=0, all `free`=1.
  - `uop_ready_out`=0, `res_st_wr_en_out`=0, `rob_incr_tail_ptr`=0.
  - RF addresses track `uop_in` combinationally.
- Mid-operation reset discards every mapping and slot with no drain.
- Station full with others free: only uops selecting the full station stall.

## Test plan
- Reset, then uop rd=x5 to RS0 at tail 3 → wr_en=01, addr 0, `rob_incr_tail_ptr`=1. Next uop rs1=x5 → `qj_valid`=1, qj=3.
- Tag for x5=3, `cdb_valid_in`=1 with addr 3, data 0xDEAD in the same cycle as a uop reading x5 → `qj_valid`=0, vj=0xDEAD. The following cycle x5 reads from the RF.
- Fill RS1 with 8 accepts → ready drops for sel=1 but stays 1 for sel=0. Release slot 5 → the next sel=1 uop gets addr 5 one cycle later.
- `rob_full_in`=1 with a valid uop → ready=0, no write, no increment. Deassert → accepted with unchanged fields.
- uop rd=x7, rs1=x7 while x7 is mapped to tag 2, tail 9 → qj=2; x7 then maps to 9. A CDB for tag 2 the next cycle leaves `tv[x7]`=1.
- `flush_in` with 3 pending tags and 4 occupied slots → next cycle all sources read the RF and slot 0 is allocated again. Async reset mid-burst → outputs 0 immediately.

Source files
------------

// File: rtl/rename_multi_if.sv
// Shared uop / reservation-station cell types and the decode-to-dispatch bus.
// Field widths follow the default PRF (32 regs) and ROB (16 entries) sizing.
package rename_multi_pkg;
    localparam int unsigned REG_IDX_W       = 5;
    localparam int unsigned ROB_TAG_W       = 4;
    localparam int unsigned RES_ST_OP_WIDTH = 8;

    typedef struct packed {
        logic [3:0] fu_op;
        logic [3:0] optype;
    } uop_ic_t;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          imm;
        logic                 imm_valid;
        logic [REG_IDX_W-1:0] rd;
        logic                 rd_valid;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        uop_ic_t              uop_ic;
    } uop_t;

    typedef struct packed {
        logic                       busy;
        logic [RES_ST_OP_WIDTH-1:0] op;
        logic [31:0]                vj;
        logic [31:0]                vk;
        logic                       qj_valid;
        logic [ROB_TAG_W-1:0]       qj;
        logic                       qk_valid;
        logic [ROB_TAG_W-1:0]       qk;
        logic [31:0]                a;
        logic [31:0]                pc;
        logic [ROB_TAG_W-1:0]       rob_addr;
        logic [REG_IDX_W-1:0]       dest;
    } res_st_cell_t;
endpackage

interface rename_multi_if #(
    parameter int unsigned RS_COUNT = 2,
    parameter int unsigned RS_DEPTH = 8,
    localparam int unsigned SEL_W  = (RS_COUNT > 1) ? $clog2(RS_COUNT) : 1,
    localparam int unsigned SLOT_W = $clog2(RS_DEPTH)
);
    rename_multi_pkg::uop_t         uop_in;
    logic [SEL_W-1:0]               uop_rs_sel_in;
    logic                           uop_ready_out;
    logic [RS_COUNT-1:0]            res_st_wr_en_out;
    logic [SLOT_W-1:0]              res_st_wr_addr_out;
    rename_multi_pkg::res_st_cell_t res_st_data_out;

    modport master (
        output uop_in, uop_rs_sel_in,
        input  uop_ready_out, res_st_wr_en_out, res_st_wr_addr_out, res_st_data_out
    );

    modport slave (
        input  uop_in, uop_rs_sel_in,
        output uop_ready_out, res_st_wr_en_out, res_st_wr_addr_out, res_st_data_out
    );
endinterface

// File: rtl/rename_multi.sv
// Rename stage: one uop per cycle against a ROB-tag table, dispatched into one
// of RS_COUNT reservation stations with per-station free-slot bitmaps.
module rename_multi #(
    parameter int unsigned RS_COUNT  = 2,
    parameter int unsigned RS_DEPTH  = 8,
    parameter int unsigned ROB_DEPTH = 2 ** rename_multi_pkg::ROB_TAG_W,
    parameter int unsigned PRF_DEPTH = 2 ** rename_multi_pkg::REG_IDX_W,
    localparam int unsigned ROB_AW = $clog2(ROB_DEPTH),
    localparam int unsigned PRF_AW = $clog2(PRF_DEPTH),
    localparam int unsigned SLOT_W = $clog2(RS_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    rename_multi_if.slave              bus,
    output logic [PRF_AW-1:0]          phy_rf_rs1_addr_out,
    output logic [PRF_AW-1:0]          phy_rf_rs2_addr_out,
    input  logic [31:0]                phy_rf_rs1_data_in,
    input  logic [31:0]                phy_rf_rs2_data_in,
    input  logic [RS_COUNT-1:0]        res_st_release_in,
    input  logic [RS_COUNT*SLOT_W-1:0] res_st_release_addr_in,
    input  logic [ROB_AW-1:0]          rob_tail_ptr,
    input  logic                       rob_full_in,
    output logic                       rob_incr_tail_ptr,
    input  logic                       cdb_valid_in,
    input  logic [ROB_AW-1:0]          cdb_rob_addr_in,
    input  logic [31:0]                cdb_data_in,
    input  logic                       flush_in
);
    typedef struct packed {
        logic              q_valid;
        logic [ROB_AW-1:0] q;
        logic [31:0]       v;
    } operand_t;

    logic [PRF_DEPTH-1:0][ROB_AW-1:0]  tag;
    logic [PRF_DEPTH-1:0]              tv;
    logic [RS_COUNT-1:0][RS_DEPTH-1:0] free;
    logic [RS_COUNT-1:0][RS_DEPTH-1:0] free_nxt;

    logic              uop_valid;
    logic              sel_ok;
    logic              accept;
    logic [RS_DEPTH-1:0] free_sel;
    logic [SLOT_W-1:0] alloc_addr;
    logic              alloc_found;
    operand_t          opj;
    operand_t          opk;

    function automatic operand_t resolve(
        input logic [PRF_AW-1:0] rs,
        input logic              pending,
        input logic [ROB_AW-1:0] ptag,
        input logic [31:0]       rf_data,
        input logic              cdb_v,
        input logic [ROB_AW-1:0] cdb_tag,
        input logic [31:0]       cdb_data
    );
        operand_t o;
        o = '0;
        if (rs == '0) begin
            o = '0;
        end else if (pending && cdb_v && (cdb_tag == ptag)) begin
            o.v = cdb_data;
        end else if (pending) begin
            o.q_valid = 1'b1;
            o.q       = ptag;
        end else begin
            o.v = rf_data;
        end
        return o;
    endfunction

    assign uop_valid           = bus.uop_in.uop_ic.optype[0];
    assign sel_ok              = 32'(bus.uop_rs_sel_in) < RS_COUNT;
    assign phy_rf_rs1_addr_out = bus.uop_in.rs1;
    assign phy_rf_rs2_addr_out = bus.uop_in.rs2;

    always_comb begin
        free_sel = '0;
        if (sel_ok) begin
            free_sel = free[bus.uop_rs_sel_in];
        end
    end

    // Lowest free slot of the selected station.
    always_comb begin
        alloc_addr  = '0;
        alloc_found = 1'b0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (free_sel[i] && !alloc_found) begin
                alloc_addr  = SLOT_W'(i);
                alloc_found = 1'b1;
            end
        end
    end

    assign bus.uop_ready_out = rst & ~flush_in & ~rob_full_in & alloc_found;
    assign accept            = uop_valid & bus.uop_ready_out;
    assign rob_incr_tail_ptr = accept;
    assign bus.res_st_wr_addr_out = alloc_addr;

    always_comb begin
        bus.res_st_wr_en_out = '0;
        if (accept) begin
            bus.res_st_wr_en_out[bus.uop_rs_sel_in] = 1'b1;
        end
    end

    always_comb begin
        opj = resolve(bus.uop_in.rs1, tv[bus.uop_in.rs1], tag[bus.uop_in.rs1],
                      phy_rf_rs1_data_in, cdb_valid_in, cdb_rob_addr_in, cdb_data_in);
        opk = resolve(bus.uop_in.rs2, tv[bus.uop_in.rs2], tag[bus.uop_in.rs2],
                      phy_rf_rs2_data_in, cdb_valid_in, cdb_rob_addr_in, cdb_data_in);
    end

    always_comb begin
        bus.res_st_data_out          = '0;
        bus.res_st_data_out.busy     = 1'b1;
        bus.res_st_data_out.op       = bus.uop_in[rename_multi_pkg::RES_ST_OP_WIDTH-1:0];
        bus.res_st_data_out.vj       = opj.v;
        bus.res_st_data_out.vk       = opk.v;
        bus.res_st_data_out.qj_valid = opj.q_valid;
        bus.res_st_data_out.qj       = opj.q;
        bus.res_st_data_out.qk_valid = opk.q_valid;
        bus.res_st_data_out.qk       = opk.q;
        bus.res_st_data_out.a        = bus.uop_in.imm_valid ? bus.uop_in.imm : '0;
        bus.res_st_data_out.pc       = bus.uop_in.pc;
        bus.res_st_data_out.rob_addr = rob_tail_ptr;
        bus.res_st_data_out.dest     = bus.uop_in.rd_valid ? bus.uop_in.rd : '0;
    end

    // CDB clears come first so a same-cycle rename of that register wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tv  <= '0;
            tag <= '0;
        end else if (flush_in) begin
            tv <= '0;
        end else begin
            for (int unsigned r = 0; r < PRF_DEPTH; r++) begin
                if (cdb_valid_in && tv[r] && (tag[r] == cdb_rob_addr_in)) begin
                    tv[r] <= 1'b0;
                end
            end
            if (accept && bus.uop_in.rd_valid && (bus.uop_in.rd != '0)) begin
                tag[bus.uop_in.rd] <= rob_tail_ptr;
                tv[bus.uop_in.rd]  <= 1'b1;
            end
        end
    end

    always_comb begin
        free_nxt = free;
        for (int unsigned s = 0; s < RS_COUNT; s++) begin
            if (res_st_release_in[s]) begin
                free_nxt[s][res_st_release_addr_in[s*SLOT_W +: SLOT_W]] = 1'b1;
            end
        end
        if (accept) begin
            free_nxt[bus.uop_rs_sel_in][alloc_addr] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            free <= '1;
        end else if (flush_in) begin
            free <= '1;
        end else begin
            free <= free_nxt;
        end
    end
endmodule
